lfsr_prng: RTL and testbench
============================

Name: lfsr_prng

Overview:
- Parametrised Fibonacci LFSR pseudo-random source for testbench stimulus: randomised backpressure, delay injection and data scrambling.
- Produces OUT_W-bit words, one LFSR step per cycle, through a valid/ready handshake.
- Supports runtime reseeding.
- Detects and repairs the all-zero lock-up state.
- One instance per random stream; several may share CLK.

Parameters:
- WIDTH, 16, LFSR length. Legal values 8, 16, 24, 32; any other value is an elaboration error.
- OUT_W, 16, bits per output word, 1..32.
- SEED, 'h1 (WIDTH bits), reset value and lock-up replacement value. Must be non-zero.

Ports:
- CLK in 1 clock.
- RSTn in 1 asynchronous active-low reset.
- seed_valid in 1 seed load request.
- seed_data in WIDTH new LFSR state.
- seed_ready out 1 constant 1; a seed is accepted on any cycle.
- rnd_valid out 1 output word available.
- rnd_ready in 1 consumer accepts word.
- rnd_data out OUT_W random word.
- lfsr_state out WIDTH current LFSR register, for debug and period checks.
- lockup_cnt out 8 zero-seed repair count (see Optional Feature).

Behaviour:
- One clock (CLK). Reset is asynchronous, active-low (RSTn).
- Reset values: state=SEED, buf=0, cnt=0, FSM=FILL, rnd_valid=0, lockup_cnt=0.
- Taps are maximal-length, bit indices of state:
  - WIDTH 8: 7,5,4,3.
  - WIDTH 16: 15,14,12,3.
  - WIDTH 24: 23,22,21,16.
  - WIDTH 32: 31,21,1,0.
- tap = XOR of the tapped bits.
- Step: state <= {state[WIDTH-2:0], tap}; buf <= {buf[OUT_W-2:0], tap}.
- FSM FILL:
  - One step per cycle; cnt increments.
  - When cnt==OUT_W-1, the step is taken, cnt clears, and the FSM goes to HOLD.
- FSM HOLD:
  - rnd_valid=1; rnd_data=buf.
  - No stepping: state and buf are frozen, and rnd_data stays stable under backpressure.
  - On rnd_valid&&rnd_ready, go to FILL; rnd_valid deasserts the next cycle.
- Latency: the first word is valid OUT_W cycles after reset release. Sustained throughput is one word per OUT_W+1 cycles.
- Seed load (seed_valid=1, any state):
  - state <= seed_data, or SEED if seed_data==0.
  - buf, cnt clear; FSM goes to FILL; rnd_valid drops the next cycle.
  - The seed has priority over a step in the same cycle; that cycle does not step.
  - If a handshake coincides with a seed load, the word counts as consumed. No duplicate word is produced.
- Lock-up: state can never be 0. A zero seed is the only entry path and is always replaced by SEED.
- Reset mid-FILL or mid-HOLD: rnd_valid goes 0 asynchronously; the partial word is discarded.
- Period: 2^WIDTH-1 steps before state repeats.

Optional Feature:
- Macro LFSR_LOCKUP_CNT_EN.
- Defined: lockup_cnt increments, saturating at 255, on each accepted zero seed. Reset clears it.
- Undefined: lockup_cnt is tied to 8'h0 and no counter flops exist. Zero-seed replacement still occurs.

Decomposition:
- Package lfsr_pkg holds:
  - the tap mask function lfsr_taps(WIDTH) returning a WIDTH-bit mask;
  - FSM state encoding FILL=1'b0, HOLD=1'b1;
  - the constant LOCKUP_CNT_W=8.
- One natural sub-module, lfsr_core: the state register, tap XOR, seed/zero replacement and step enable. lfsr_prng adds the word buffer, counter, FSM and handshake.

Test Plan:
- Reset, WIDTH=16, OUT_W=16, SEED=16'h0001, rnd_ready=1 -> rnd_valid rises exactly 16 cycles after RSTn release; rnd_data matches a golden software model of the same taps and step rule.
- OUT_W=1, rnd_ready=1, 3*65535 handshakes -> lfsr_state returns to 16'h0001 after exactly 65535 steps, and never earlier; state is never 0.
- In HOLD, rnd_ready=0 for 100 cycles -> rnd_data and lfsr_state constant; on ready, the next word equals the model continuation.
- seed_valid with seed_data=16'h0000 -> lfsr_state=16'h0001 next cycle; lockup_cnt=1 with LFSR_LOCKUP_CNT_EN, 0 without; 300 zero seeds -> lockup_cnt saturates at 255.
- seed_valid=1 with seed_data=16'hACE1 in the same cycle as rnd_valid&&rnd_ready -> lfsr_state=16'hACE1, rnd_valid=0 next cycle, next word valid 16 cycles later.
- RSTn low at cnt=7 of FILL -> rnd_valid=0 immediately; after release, the first word is identical to the post-reset word of the first scenario.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the lfsr_prng pseudo-random source: tap table,
// FSM encoding and lock-up counter width.
package lfsr_pkg;

    localparam int LOCKUP_CNT_W = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fsm_e;

    function automatic logic lfsr_width_ok(input int width);
        return (width == 8) || (width == 16) || (width == 24) || (width == 32);
    endfunction

    // Maximal-length Fibonacci taps; callers keep the low WIDTH bits of the mask.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] mask;
        mask = '0;
        case (width)
            8:       mask = 32'h0000_00B8;  // 7,5,4,3
            16:      mask = 32'h0000_D008;  // 15,14,12,3
            24:      mask = 32'h00E1_0000;  // 23,22,21,16
            32:      mask = 32'h8020_0003;  // 31,21,1,0
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with tap XOR, step enable and seed load; a zero seed
// is replaced by SEED so the register can never enter the all-zero state.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_valid_i,
    input  logic [WIDTH-1:0] seed_data_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] state_o,
    output logic             tap_o
);

    if (!lfsr_width_ok(WIDTH)) begin : g_bad_width
        $error("lfsr_core: WIDTH must be 8, 16, 24 or 32");
    end

    localparam logic [31:0]      TAPS_ALL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAP_MASK = TAPS_ALL[WIDTH-1:0];

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             tap;

    assign tap = ^(state_q & TAP_MASK);

    // A seed load wins over a step requested in the same cycle.
    always_comb begin
        state_d = state_q;
        if (seed_valid_i) begin
            state_d = (seed_data_i == '0) ? SEED : seed_data_i;
        end else if (step_i) begin
            state_d = {state_q[WIDTH-2:0], tap};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
    assign tap_o   = tap;

endmodule

// File: rtl/lfsr_prng.sv
// Fibonacci LFSR word source with valid/ready output and runtime reseeding.
// Define LFSR_LOCKUP_CNT_EN to count zero-seed repairs on lockup_cnt.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter int               OUT_W = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    seed_valid,
    input  logic [WIDTH-1:0]        seed_data,
    output logic                    seed_ready,
    output logic                    rnd_valid,
    input  logic                    rnd_ready,
    output logic [OUT_W-1:0]        rnd_data,
    output logic [WIDTH-1:0]        lfsr_state,
    output logic [LOCKUP_CNT_W-1:0] lockup_cnt
);

    if (OUT_W < 1 || OUT_W > 32) begin : g_bad_out_w
        $error("lfsr_prng: OUT_W must be in 1..32");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_prng: SEED must be non-zero");
    end

    localparam int               CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

    fsm_e             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] word_q, word_d, word_shift;
    logic             step;
    logic             tap;

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_core (
        .clk          (CLK),
        .rst_n        (RSTn),
        .seed_valid_i (seed_valid),
        .seed_data_i  (seed_data),
        .step_i       (step),
        .state_o      (lfsr_state),
        .tap_o        (tap)
    );

    if (OUT_W == 1) begin : g_shift_1
        assign word_shift = tap;
    end else begin : g_shift_n
        assign word_shift = {word_q[OUT_W-2:0], tap};
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        word_d = word_q;
        step   = 1'b0;
        if (seed_valid) begin
            // Restart the word; a coincident handshake still consumes it.
            fsm_d  = FILL;
            cnt_d  = '0;
            word_d = '0;
        end else begin
            case (fsm_q)
                FILL: begin
                    step   = 1'b1;
                    word_d = word_shift;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        fsm_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (rnd_ready) begin
                        fsm_d = FILL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fsm_q  <= FILL;
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign seed_ready = 1'b1;
    assign rnd_valid  = (fsm_q == HOLD);
    assign rnd_data   = word_q;

`ifdef LFSR_LOCKUP_CNT_EN
    logic [LOCKUP_CNT_W-1:0] lockup_q, lockup_d;

    always_comb begin
        lockup_d = lockup_q;
        if (seed_valid && (seed_data == '0) && (lockup_q != '1)) begin
            lockup_d = lockup_q + LOCKUP_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            lockup_q <= '0;
        end else begin
            lockup_q <= lockup_d;
        end
    end

    assign lockup_cnt = lockup_q;
`else
    assign lockup_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: golden LFSR model, randomized
// backpressure and reseeding, period, lock-up and reset scenarios.
module tb_lfsr_prng;

`ifdef LFSR_LOCKUP_CNT_EN
    localparam int EXP_LC_ONE = 1;
    localparam int EXP_LC_SAT = 255;
`else
    localparam int EXP_LC_ONE = 0;
    localparam int EXP_LC_SAT = 0;
`endif

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instance A: WIDTH=16, OUT_W=16
    logic        RSTn, seed_valid, seed_ready, rnd_valid, rnd_ready;
    logic [15:0] seed_data, rnd_data, lfsr_state;
    logic [7:0]  lockup_cnt;
    // Instance B: WIDTH=8, OUT_W=1 (period check)
    logic        b_rst_n, b_seed_valid, b_seed_ready, b_valid, b_ready;
    logic [7:0]  b_seed_data, b_state, b_lockup;
    logic [0:0]  b_data;
    // Instances C (WIDTH=32, OUT_W=32) and D (WIDTH=24, OUT_W=8)
    logic        cd_rst_n;
    logic        c_seed_valid, c_seed_ready, c_valid, c_ready;
    logic [31:0] c_seed_data, c_data, c_state;
    logic [7:0]  c_lockup;
    logic        d_seed_valid, d_seed_ready, d_valid, d_ready;
    logic [23:0] d_seed_data, d_state;
    logic [7:0]  d_data, d_lockup;

    lfsr_prng #(.WIDTH(16), .OUT_W(16), .SEED(16'h0001)) u_a (
        .CLK(CLK), .RSTn(RSTn), .seed_valid(seed_valid), .seed_data(seed_data),
        .seed_ready(seed_ready), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .rnd_data(rnd_data), .lfsr_state(lfsr_state), .lockup_cnt(lockup_cnt));

    lfsr_prng #(.WIDTH(8), .OUT_W(1), .SEED(8'h01)) u_b (
        .CLK(CLK), .RSTn(b_rst_n), .seed_valid(b_seed_valid), .seed_data(b_seed_data),
        .seed_ready(b_seed_ready), .rnd_valid(b_valid), .rnd_ready(b_ready),
        .rnd_data(b_data), .lfsr_state(b_state), .lockup_cnt(b_lockup));

    lfsr_prng #(.WIDTH(32), .OUT_W(32), .SEED(32'h1)) u_c (
        .CLK(CLK), .RSTn(cd_rst_n), .seed_valid(c_seed_valid), .seed_data(c_seed_data),
        .seed_ready(c_seed_ready), .rnd_valid(c_valid), .rnd_ready(c_ready),
        .rnd_data(c_data), .lfsr_state(c_state), .lockup_cnt(c_lockup));

    lfsr_prng #(.WIDTH(24), .OUT_W(8), .SEED(24'h1)) u_d (
        .CLK(CLK), .RSTn(cd_rst_n), .seed_valid(d_seed_valid), .seed_data(d_seed_data),
        .seed_ready(d_seed_ready), .rnd_valid(d_valid), .rnd_ready(d_ready),
        .rnd_data(d_data), .lfsr_state(d_state), .lockup_cnt(d_lockup));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Golden model: shift left, feed back the parity of the tapped bits.
    function automatic logic [31:0] model_step(input logic [31:0] s, input int w);
        int          taps[4];
        bit          fb;
        logic [63:0] t, mask;
        case (w)
            8:       taps = '{7, 5, 4, 3};
            16:      taps = '{15, 14, 12, 3};
            24:      taps = '{23, 22, 21, 16};
            default: taps = '{31, 21, 1, 0};
        endcase
        fb = 1'b0;
        foreach (taps[i]) fb ^= s[taps[i]];
        mask = (64'h1 << w) - 64'h1;
        t    = (({32'h0, s} << 1) | {63'h0, fb}) & mask;
        return t[31:0];
    endfunction

    // A word is the sequence of n feedback bits, first bit in the MSB.
    task automatic model_word(input int w, input int n, inout logic [31:0] s,
                              output logic [31:0] word);
        word = '0;
        for (int i = 0; i < n; i++) begin
            s    = model_step(s, w);
            word = {word[30:0], s[0]};
        end
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!rnd_valid && n < 200);
        if (!rnd_valid) check({tag, "_timeout"}, {31'h0, rnd_valid}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m, mb, mc, md, exp_w, first_word, first_state;
        logic [15:0] seed_v;
        int          n, words, cyc, steps, cw, dw;
        bit          seen, seed_chk;

        RSTn = 1'b0; seed_valid = 1'b0; seed_data = '0; rnd_ready = 1'b1;
        b_rst_n = 1'b0; b_seed_valid = 1'b0; b_seed_data = '0; b_ready = 1'b1;
        cd_rst_n = 1'b0; c_seed_valid = 1'b0; c_seed_data = '0; c_ready = 1'b1;
        d_seed_valid = 1'b0; d_seed_data = '0; d_ready = 1'b1;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_valid", {31'h0, rnd_valid}, 0);
        check("rst_state", lfsr_state, 32'h1);
        check("rst_data", rnd_data, 0);
        check("rst_lockup", lockup_cnt, 0);
        check("rst_seed_ready", {31'h0, seed_ready}, 1);
        check("rst_b_state", b_state, 32'h1);
        check("rst_c_state", c_state, 32'h1);
        check("rst_d_state", d_state, 32'h1);
        check("rst_cd_ready", {30'h0, c_seed_ready, d_seed_ready}, 32'h3);
        check("rst_b_seed_ready", {31'h0, b_seed_ready}, 1);
        check("rst_bcd_lockup", {8'h0, b_lockup, c_lockup, d_lockup}, 0);

        // First word latency and contents
        RSTn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            if (k == 15) check("p1_valid_early", {31'h0, rnd_valid}, 0);
        end
        check("p1_valid_at_16", {31'h0, rnd_valid}, 1);
        m = 32'h1;
        model_word(16, 16, m, exp_w);
        first_word  = exp_w;
        first_state = m;
        check("p1_word", rnd_data, exp_w);
        check("p1_state", lfsr_state, m);
        wait_valid("p1_next", n);
        check("p1_throughput", n, 17);
        model_word(16, 16, m, exp_w);
        check("p1_word2", rnd_data, exp_w);

        // Randomized backpressure with occasional reseeds
        words = 0; cyc = 0; seen = 1'b0; seed_chk = 1'b0; seed_v = '0;
        while (words < 20 && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            seed_valid = 1'b0;
            if (seed_chk) begin
                check("p2_seed_state", lfsr_state, {16'h0, seed_v});
                check("p2_seed_valid", {31'h0, rnd_valid}, 0);
                seed_chk = 1'b0;
            end
            if (rnd_valid) begin
                if (!seen) begin
                    model_word(16, 16, m, exp_w);
                    check("p2_word", rnd_data, exp_w);
                    check("p2_state", lfsr_state, m);
                    seen = 1'b1;
                end else begin
                    check("p2_stable", rnd_data, exp_w);
                end
            end
            rnd_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) begin
                seed_v     = 16'($urandom_range(1, 65535));
                seed_valid = 1'b1;
                seed_data  = seed_v;
                m          = {16'h0, seed_v};
                seen       = 1'b0;
                seed_chk   = 1'b1;
            end else if (rnd_valid && rnd_ready) begin
                seen = 1'b0;
                words++;
            end
        end
        if (words < 20) check("p2_words", words, 20);
        @(negedge CLK);
        seed_valid = 1'b0;
        rnd_ready  = 1'b0;

        // Long backpressure in HOLD
        wait_valid("p3", n);
        model_word(16, 16, m, exp_w);
        check("p3_word", rnd_data, exp_w);
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            check("p3_hold_data", rnd_data, exp_w);
            check("p3_hold_state", lfsr_state, m);
        end
        rnd_ready = 1'b1;
        wait_valid("p3_cont", n);
        check("p3_cont_latency", n, 17);
        model_word(16, 16, m, exp_w);
        check("p3_cont_word", rnd_data, exp_w);

        // Zero seeds: replacement and counter saturation
        rnd_ready  = 1'b0;
        seed_valid = 1'b1;
        seed_data  = 16'h0000;
        @(negedge CLK);
        check("p4_zero_state", lfsr_state, 32'h1);
        check("p4_zero_valid", {31'h0, rnd_valid}, 0);
        check("p4_lockup_one", lockup_cnt, EXP_LC_ONE);
        repeat (299) @(negedge CLK);
        check("p4_lockup_sat", lockup_cnt, EXP_LC_SAT);
        check("p4_state_after", lfsr_state, 32'h1);
        seed_valid = 1'b0;
        m = 32'h1;

        // Seed coinciding with a handshake
        wait_valid("p5_pre", n);
        check("p5_pre_latency", n, 16);
        model_word(16, 16, m, exp_w);
        check("p5_pre_word", rnd_data, exp_w);
        rnd_ready  = 1'b1;
        seed_valid = 1'b1;
        seed_data  = 16'hACE1;
        @(negedge CLK);
        seed_valid = 1'b0;
        rnd_ready  = 1'b0;
        check("p5_seed_state", lfsr_state, 32'hACE1);
        check("p5_seed_valid", {31'h0, rnd_valid}, 0);
        m = 32'hACE1;
        wait_valid("p5_post", n);
        check("p5_post_latency", n, 16);
        model_word(16, 16, m, exp_w);
        check("p5_post_word", rnd_data, exp_w);

        // Asynchronous reset mid-HOLD, then mid-FILL at cnt=7
        #2 RSTn = 1'b0;
        #1;
        check("p6_hold_rst_valid", {31'h0, rnd_valid}, 0);
        check("p6_hold_rst_state", lfsr_state, 32'h1);
        check("p6_hold_rst_lockup", lockup_cnt, 0);
        @(negedge CLK);
        RSTn      = 1'b1;
        rnd_ready = 1'b1;
        repeat (7) @(negedge CLK);
        m = 32'h1;
        repeat (7) m = model_step(m, 16);
        check("p6_fill7_state", lfsr_state, m);
        #2 RSTn = 1'b0;
        #1;
        check("p6_fill_rst_valid", {31'h0, rnd_valid}, 0);
        check("p6_fill_rst_state", lfsr_state, 32'h1);
        @(negedge CLK);
        RSTn      = 1'b1;
        rnd_ready = 1'b0;
        wait_valid("p6_after", n);
        check("p6_after_latency", n, 16);
        check("p6_after_word", rnd_data, first_word);
        check("p6_after_state", lfsr_state, first_state);

        // Period of the 8-bit LFSR, one bit per word
        b_rst_n = 1'b1;
        mb = 32'h1; steps = 0; cyc = 0;
        while (steps < 765 && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
            if (b_valid) begin
                mb = model_step(mb, 8);
                steps++;
                check("b_data", {31'h0, b_data}, {31'h0, mb[0]});
                check("b_state", b_state, mb);
                check("b_period", {31'h0, (b_state == 8'h01)}, {31'h0, (steps % 255 == 0)});
                check("b_nonzero", {31'h0, (b_state != 8'h00)}, 1);
            end
        end
        if (steps < 765) check("b_steps", steps, 765);

        // 32-bit and 24-bit tap sets
        cd_rst_n = 1'b1;
        mc = 32'h1; md = 32'h1; cw = 0; dw = 0; cyc = 0;
        while (cw < 4 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (c_valid) begin
                model_word(32, 32, mc, exp_w);
                check("c_word", c_data, exp_w);
                check("c_state", c_state, mc);
                cw++;
            end
            if (d_valid) begin
                model_word(24, 8, md, exp_w);
                check("d_word", {24'h0, d_data}, exp_w);
                check("d_state", {8'h0, d_state}, md);
                dw++;
            end
        end
        check("c_words", cw, 4);
        check("d_words", dw, 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
